// File: rtl/flush_ctrl.sv
// Pipeline flush/redirect controller: arbitrates exceptions and branch mispredicts, holds flush through a drain window.
// Optional perf counters (mispred_cnt, exc_cnt) enabled by defining FLUSH_PERF_CNT_EN.
module flush_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int BR_STAGE     = 2,
  parameter int DRAIN_CYCLES = 1,
`ifdef FLUSH_PERF_CNT_EN
  parameter int CNT_WIDTH    = 32,
`endif
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_STAGES-1:0] exc_valid,
  input  logic [DATA_WIDTH-1:0] trap_vec,
  input  logic                  br_valid,
  input  logic [DATA_WIDTH-1:0] pcp,
  input  logic [DATA_WIDTH-1:0] pcn,
  input  logic                  redirect_ack,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  pred_failed,
`ifdef FLUSH_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  mispred_cnt,
  output logic [CNT_WIDTH-1:0]  exc_cnt,
`endif
  output logic                  busy
);
  localparam int AW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [AW-1:0] BR_AGE = AW'(BR_STAGE);
  localparam logic [NUM_STAGES-1:0] BR_MASK = NUM_STAGES'((1 << BR_STAGE) - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] flush_q, flush_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [AW-1:0]         age_q, age_d;
  logic [3:0]            drain_q, drain_d;
  logic                  rv_q, rv_d;
  logic                  pf_q, pf_d;

  logic                  exc_hit, mispred, ev_exc, ev_valid, accept;
  logic [AW-1:0]         exc_age, ev_age;
  logic [NUM_STAGES-1:0] ev_mask;
  logic [DATA_WIDTH-1:0] ev_pc;

  // Oldest (highest-index) exception wins; it loses to a mispredict only when younger than BR_STAGE.
  always_comb begin
    exc_hit = 1'b0;
    exc_age = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (enable && exc_valid[i]) begin
        exc_hit = 1'b1;
        exc_age = AW'(i);
      end
    end
    mispred  = enable && br_valid && (pcp != pcn);
    ev_exc   = exc_hit && (!mispred || (exc_age >= BR_AGE));
    ev_valid = ev_exc || mispred;
    ev_age   = ev_exc ? exc_age : BR_AGE;
    ev_pc    = ev_exc ? trap_vec : pcn;
    ev_mask  = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      ev_mask[i] = ev_exc ? (AW'(i) <= exc_age) : BR_MASK[i];
    accept = ev_valid && ((state_q == IDLE) || (ev_age > age_q));
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pc_d    = pc_q;
    age_d   = age_q;
    drain_d = drain_q;
    rv_d    = rv_q;
    pf_d    = 1'b0;
    if (accept) begin
      // Preemption takes priority over a same-cycle ack.
      state_d = REDIRECT;
      flush_d = ev_mask;
      pc_d    = ev_pc;
      age_d   = ev_age;
      drain_d = '0;
      rv_d    = 1'b1;
      pf_d    = !ev_exc;
    end else begin
      case (state_q)
        REDIRECT: if (redirect_ack) begin
          rv_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
            flush_d = '0;
          end else begin
            state_d = DRAIN;
            drain_d = 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: if (drain_q <= 4'd1) begin
          state_d = IDLE;
          flush_d = '0;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flush_q <= '0;
      pc_q    <= '0;
      age_q   <= '0;
      drain_q <= '0;
      rv_q    <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
      age_q   <= age_d;
      drain_q <= drain_d;
      rv_q    <= rv_d;
      pf_q    <= pf_d;
    end
  end

`ifdef FLUSH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] mis_cnt_q, exc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= '0;
      exc_cnt_q <= '0;
    end else if (accept) begin
      if (!ev_exc && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
      if (ev_exc && (exc_cnt_q != '1))  exc_cnt_q <= exc_cnt_q + 1'b1;
    end
  end

  assign mispred_cnt = mis_cnt_q;
  assign exc_cnt     = exc_cnt_q;
`endif

  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign pred_failed    = pf_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_flush_ctrl.sv
// Directed bench for flush_ctrl: arbitration, preemption, drain window, async reset, optional counter saturation.
module tb_flush_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  exc_valid;
  logic [31:0] trap_vec;
  logic        br_valid;
  logic [31:0] pcp, pcn;
  logic        redirect_ack;
  logic [4:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pred_failed;
  logic        busy;
`ifdef FLUSH_PERF_CNT_EN
  logic [1:0]  mispred_cnt, exc_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  flush_ctrl #(
    .NUM_STAGES(5), .BR_STAGE(2), .DRAIN_CYCLES(1),
`ifdef FLUSH_PERF_CNT_EN
    .CNT_WIDTH(2),
`endif
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .exc_valid(exc_valid),
    .trap_vec(trap_vec), .br_valid(br_valid), .pcp(pcp), .pcn(pcn),
    .redirect_ack(redirect_ack), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pred_failed(pred_failed),
`ifdef FLUSH_PERF_CNT_EN
    .mispred_cnt(mispred_cnt), .exc_cnt(exc_cnt),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] f, input logic rv,
                         input logic [31:0] pc, input logic pf, input logic b);
    chk({tag, ".flush"}, 64'(flush), 64'(f));
    chk({tag, ".rv"},    64'(redirect_valid), 64'(rv));
    chk({tag, ".pc"},    64'(redirect_pc), 64'(pc));
    chk({tag, ".pf"},    64'(pred_failed), 64'(pf));
    chk({tag, ".busy"},  64'(busy), 64'(b));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; exc_valid = '0; trap_vec = 32'h8000_0000;
    br_valid = 1'b0; pcp = '0; pcn = '0; redirect_ack = 1'b0;
    tick();
    chk_all("reset", 5'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk_all("idle", 5'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Plain mispredict, ack after 3 cycles, one drain cycle
    br_valid = 1'b1; pcp = 32'h1000; pcn = 32'h2000;
    tick(); br_valid = 1'b0;
    chk_all("mp", 5'b00011, 1'b1, 32'h2000, 1'b1, 1'b1);
    tick();
    chk_all("mp_hold1", 5'b00011, 1'b1, 32'h2000, 1'b0, 1'b1);
    tick();
    chk_all("mp_hold2", 5'b00011, 1'b1, 32'h2000, 1'b0, 1'b1);
    redirect_ack = 1'b1;
    tick(); redirect_ack = 1'b0;
    chk_all("mp_drain", 5'b00011, 1'b0, 32'h2000, 1'b0, 1'b1);
    tick();
    chk("mp_done.flush", 64'(flush), 64'h0);
    chk("mp_done.busy", 64'(busy), 64'h0);

    // Older exception beats a same-cycle mispredict
    exc_valid = 5'b01000; br_valid = 1'b1; pcp = 32'h10; pcn = 32'h20;
    tick(); exc_valid = '0; br_valid = 1'b0;
    chk_all("exc_vs_mp", 5'b01111, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    redirect_ack = 1'b1;
    tick(); redirect_ack = 1'b0;
    tick();
    chk("exc_vs_mp_done.busy", 64'(busy), 64'h0);

    // Mispredict pending, preempted by older exception at stage 4
    br_valid = 1'b1; pcp = 32'h100; pcn = 32'h200;
    tick(); br_valid = 1'b0;
    chk("pre.flush", 64'(flush), 64'h03);
    tick();
    exc_valid = 5'b10000;
    tick(); exc_valid = '0;
    chk_all("preempt", 5'b11111, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    trap_vec = 32'h4444; exc_valid = 5'b00010;
    tick(); exc_valid = '0;
    chk_all("younger_ign", 5'b11111, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    // enable low: pending sequence still completes, new events blocked
    enable = 1'b0; redirect_ack = 1'b1;
    tick(); redirect_ack = 1'b0;
    chk_all("dis_drain", 5'b11111, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    chk("dis_idle.busy", 64'(busy), 64'h0);
    br_valid = 1'b1; pcp = 32'h300; pcn = 32'h400;
    tick(); br_valid = 1'b0;
    chk("dis_blocked.busy", 64'(busy), 64'h0);
    chk("dis_blocked.flush", 64'(flush), 64'h0);
    enable = 1'b1;

    // Equal age ignored; preemption wins over same-cycle ack
    trap_vec = 32'hABCD_0000;
    br_valid = 1'b1; pcp = 32'h500; pcn = 32'h600;
    tick(); br_valid = 1'b0;
    exc_valid = 5'b00100;
    tick(); exc_valid = '0;
    chk_all("equal_ign", 5'b00011, 1'b1, 32'h600, 1'b0, 1'b1);
    exc_valid = 5'b01000; redirect_ack = 1'b1;
    tick(); exc_valid = '0; redirect_ack = 1'b0;
    chk_all("pre_vs_ack", 5'b01111, 1'b1, 32'hABCD_0000, 1'b0, 1'b1);
    redirect_ack = 1'b1;
    tick(); redirect_ack = 1'b0;
    tick();

    // Async reset while a redirect is outstanding
    br_valid = 1'b1; pcp = 32'h700; pcn = 32'h800;
    tick(); br_valid = 1'b0;
    chk("rst_pre.rv", 64'(redirect_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 5'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.busy", 64'(busy), 64'h0);

`ifdef FLUSH_PERF_CNT_EN
    for (int n = 0; n < 5; n++) begin
      br_valid = 1'b1; pcp = 32'h10; pcn = 32'h90;
      tick(); br_valid = 1'b0;
      redirect_ack = 1'b1;
      tick(); redirect_ack = 1'b0;
      tick();
    end
    chk("mispred_cnt_sat", 64'(mispred_cnt), 64'h3);
    chk("exc_cnt", 64'(exc_cnt), 64'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
